// File: rtl/spd_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// The KMP transition table is built from next_state() when the detector elaborates.
package spd_pkg;

  localparam int SPD_MAX_PAT_LEN = 8;
  localparam int SPD_PAT_LEN     = 4;
  localparam logic [3:0] SPD_PATTERN = 4'b1011;
  localparam int SPD_STATE_W     = $clog2(SPD_MAX_PAT_LEN) + 1;

  typedef enum logic [SPD_STATE_W-1:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7
  } spd_state_e;

  // Longest proper prefix of pat that is a suffix of (first k pattern bits + b).
  function automatic int next_state(input int k, input logic b,
                                    input logic [7:0] pat, input int len);
    int   best;
    int   pos;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j < SPD_MAX_PAT_LEN; j++) begin
      if ((j <= k + 1) && (j < len)) begin
        ok = 1'b1;
        for (int m = 0; m < SPD_MAX_PAT_LEN; m++) begin
          if (m < j) begin
            pos = k + 1 - j + m;
            if (pos == k) sb = b;
            else          sb = 1'(pat >> (len - 1 - pos));
            if (sb != 1'(pat >> (len - 1 - m))) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc, stop at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Overlapping serial pattern detector (KMP FSM) with registered match pulse and
// saturating match count. Optional sticky 'seen' flag under SPD_STICKY_FLAG_EN.
module serial_pattern_detector
  import spd_pkg::*;
#(
  parameter int                 PAT_LEN = SPD_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SPD_PATTERN),
  parameter int                 CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      din,
`ifdef SPD_STICKY_FLAG_EN
  input  logic                      clr_flag,
  output logic                      seen,
`endif
  output logic                      match,
  output logic [CNT_W-1:0]          match_count,
  output logic [$clog2(PAT_LEN):0]  state_dbg
);

  localparam int         SW     = $clog2(PAT_LEN) + 1;
  localparam logic [7:0] PAT8   = 8'(PATTERN);
  localparam spd_state_e LAST_S = spd_state_e'(SPD_STATE_W'(PAT_LEN - 1));

  spd_state_e state_q;
  spd_state_e state_d;
  logic       match_q;
  logic       hit_d;
  spd_state_e nxt_lo [PAT_LEN];
  spd_state_e nxt_hi [PAT_LEN];

  for (genvar k = 0; k < PAT_LEN; k++) begin : g_kmp
    localparam int N0 = next_state(k, 1'b0, PAT8, PAT_LEN);
    localparam int N1 = next_state(k, 1'b1, PAT8, PAT_LEN);
    assign nxt_lo[k] = spd_state_e'(SPD_STATE_W'(N0));
    assign nxt_hi[k] = spd_state_e'(SPD_STATE_W'(N1));
  end

  // Table lookup of the next state; unreachable encodings recover to S0.
  always_comb begin
    state_d = S0;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (state_q == spd_state_e'(SPD_STATE_W'(k))) begin
        state_d = din ? nxt_hi[k] : nxt_lo[k];
      end else begin
        state_d = state_d;
      end
    end
    hit_d = (state_q == LAST_S) && (din == PATTERN[0]);
  end

  // FSM state and match pulse; en=0 freezes the state and drops the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      match_q <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      match_q <= hit_d;
    end else begin
      state_q <= state_q;
      match_q <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (en && hit_d),
    .count (match_count)
  );

`ifdef SPD_STICKY_FLAG_EN
  logic seen_q;

  // Sticky flag: a match on the same edge as clr_flag keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= 1'b0;
    end else if (en && hit_d) begin
      seen_q <= 1'b1;
    end else if (clr_flag) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_q;
    end
  end

  assign seen = seen_q;
`endif

  assign match     = match_q;
  assign state_dbg = SW'(state_q);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench: two detectors (1011/len4/8-bit count and 11/len2/3-bit count)
// checked every cycle against a history-based model plus literal expectations.
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       reset, en, din;
  logic       clr_req;
  logic       m1, m2;
  logic [7:0] c1;
  logic [2:0] c2;
  logic [2:0] s1;
  logic [1:0] s2;
`ifdef SPD_STICKY_FLAG_EN
  logic       seen1, seen2;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .din(din),
`ifdef SPD_STICKY_FLAG_EN
    .clr_flag(clr_req), .seen(seen1),
`endif
    .match(m1), .match_count(c1), .state_dbg(s1)
  );

  serial_pattern_detector #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(3)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .din(din),
`ifdef SPD_STICKY_FLAG_EN
    .clr_flag(1'b0), .seen(seen2),
`endif
    .match(m2), .match_count(c2), .state_dbg(s2)
  );

  // ---------------- model: history of accepted bits since reset ----------------
  bit hist[$];
  bit exp_m1, exp_m2, exp_seen1, armed;
  int exp_c1, exp_c2;

  function automatic bit pbit(input logic [7:0] pat, input int len, input int i);
    return bit'(1'(pat >> (len - 1 - i)));
  endfunction

  function automatic bit tail_is_prefix(input logic [7:0] pat, input int len, input int j);
    if (hist.size() < j) return 1'b0;
    for (int m = 0; m < j; m++)
      if (hist[hist.size() - j + m] != pbit(pat, len, m)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_state(input logic [7:0] pat, input int len);
    for (int j = len - 1; j > 0; j--)
      if (tail_is_prefix(pat, len, j)) return j;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always begin
    @(posedge clk);
    if (reset) begin
      hist.delete();
      exp_m1 = 1'b0; exp_m2 = 1'b0; exp_c1 = 0; exp_c2 = 0; exp_seen1 = 1'b0;
      armed = 1'b1;
    end else if (en) begin
      hist.push_back(din);
      if (hist.size() > 8) void'(hist.pop_front());
      exp_m1 = tail_is_prefix(8'h0B, 4, 4);
      exp_m2 = tail_is_prefix(8'h03, 2, 2);
      if (exp_m1 && exp_c1 < 255) exp_c1++;
      if (exp_m2 && exp_c2 < 7) exp_c2++;
      if (exp_m1) exp_seen1 = 1'b1;
      else if (clr_req) exp_seen1 = 1'b0;
    end else begin
      exp_m1 = 1'b0; exp_m2 = 1'b0;
      if (clr_req) exp_seen1 = 1'b0;
    end
    #1;
    if (armed) begin
      chk("model_match1", m1, exp_m1);
      chk("model_count1", c1, exp_c1);
      chk("model_state1", s1, model_state(8'h0B, 4));
      chk("model_match2", m2, exp_m2);
      chk("model_count2", c2, exp_c2);
      chk("model_state2", s2, model_state(8'h03, 2));
`ifdef SPD_STICKY_FLAG_EN
      chk("model_seen1", seen1, exp_seen1);
      chk("model_seen2", seen2, exp_c2 != 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit e, input bit d);
    @(negedge clk);
    reset = r; en = e; din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bit'(1'(v >> i)));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; din = 1'b0; clr_req = 1'b0;
    armed = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_match", m1, 0);
    chk("reset_count", c1, 0);
    chk("reset_state", s1, 0);

    feed(16'b1011, 4);
    chk("single_match", m1, 1);
    chk("single_count", c1, 1);
    chk("single_state", s1, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("pulse_width", m1, 0);

    step(1'b1, 1'b0, 1'b0);
    feed(16'b1011011, 7);
    chk("overlap_match", m1, 1);
    chk("overlap_count", c1, 2);

    step(1'b1, 1'b0, 1'b0);
    feed(16'b100, 3);
    chk("nomatch_state3", s1, 0);
    feed(16'b1010, 4);
    // trailing 10 is a prefix of 1011
    chk("nomatch_state7", s1, 2);
    chk("nomatch_count", c1, 0);

    step(1'b1, 1'b0, 1'b0);
    feed(16'b10, 2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, bit'(i % 2));
    chk("stall_state", s1, 2);
    feed(16'b11, 2);
    chk("stall_match", m1, 1);
    chk("stall_count", c1, 1);

    step(1'b1, 1'b0, 1'b0);
    feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b1);
    feed(16'b1, 1);
    chk("midreset_match", m1, 0);
    chk("midreset_count", c1, 0);
    chk("midreset_state", s1, 1);

    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("b2b_first", m2, 1);
    step(1'b0, 1'b1, 1'b1);
    chk("b2b_second", m2, 1);
    chk("b2b_count", c2, 2);

    step(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 260; r++) feed(16'b1011, 4);
    chk("sat_count1", c1, 255);
    chk("sat_match1", m1, 1);
    chk("sat_count2", c2, 7);

`ifdef SPD_STICKY_FLAG_EN
    chk("seen_set", seen1, 1);
    clr_req = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_req = 1'b0;
    chk("seen_clear", seen1, 0);
    clr_req = 1'b1;
    feed(16'b1011, 4);
    clr_req = 1'b0;
    chk("seen_set_wins", seen1, 1);
`endif

    step(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
